ps2_key_decoder: RTL

Downstream consumer of the PS/2 keyboard receiver's FIFO: pops raw scan-code bytes via a ready/next-data handshake and interprets make, break (F0) and extended (E0) prefixes. Tracks the currently held key and its ASCII equivalent, and counts distinct key presses. Outputs drive the seven-segment digit drivers (scan code, ASCII, press count) in the top level.

---
 rtl/ps2_key_decoder_pkg.sv | 14 +
 rtl/ps2_key_decoder_if.sv | 12 +
 rtl/ps2_scancode_to_ascii.sv | 52 +++++
 rtl/ps2_key_decoder.sv | 109 ++++++++++
 4 files changed

// File: rtl/ps2_key_decoder_pkg.sv
// Shared constants and FSM encoding for the PS/2 scan-code decoder.
package ps2_key_decoder_pkg;

   localparam logic [7:0] SC_BREAK   = 8'hF0;
   localparam logic [7:0] SC_EXT     = 8'hE0;
   localparam logic [7:0] ASCII_NONE = 8'h00;

   typedef enum logic [1:0] {
      ST_WAIT = 2'd0,
      ST_POP  = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Receiver FIFO handshake. kbd_data is valid whenever kbd_ready=1; a one-cycle
// low pulse on kbd_nextdata_n pops the head byte, and ready/data settle within one cycle.
interface ps2_key_decoder_if;

   logic [7:0] kbd_data;
   logic       kbd_ready;
   logic       kbd_nextdata_n;

   modport master (output kbd_data, output kbd_ready, input kbd_nextdata_n);
   modport slave  (input kbd_data, input kbd_ready, output kbd_nextdata_n);

endinterface

// File: rtl/ps2_scancode_to_ascii.sv
// Combinational set-2 scan code to lowercase ASCII table (letters and main-row digits).
module ps2_scancode_to_ascii
   import ps2_key_decoder_pkg::*;
(
   input  logic [7:0] code_i,
   output logic [7:0] ascii_o
);

   always_comb begin
      ascii_o = ASCII_NONE;
      case (code_i)
         8'h1C: ascii_o = 8'h61; // a
         8'h32: ascii_o = 8'h62;
         8'h21: ascii_o = 8'h63;
         8'h23: ascii_o = 8'h64;
         8'h24: ascii_o = 8'h65;
         8'h2B: ascii_o = 8'h66;
         8'h34: ascii_o = 8'h67;
         8'h33: ascii_o = 8'h68;
         8'h43: ascii_o = 8'h69;
         8'h3B: ascii_o = 8'h6A;
         8'h42: ascii_o = 8'h6B;
         8'h4B: ascii_o = 8'h6C;
         8'h3A: ascii_o = 8'h6D;
         8'h31: ascii_o = 8'h6E;
         8'h44: ascii_o = 8'h6F;
         8'h4D: ascii_o = 8'h70;
         8'h15: ascii_o = 8'h71;
         8'h2D: ascii_o = 8'h72;
         8'h1B: ascii_o = 8'h73;
         8'h2C: ascii_o = 8'h74;
         8'h3C: ascii_o = 8'h75;
         8'h2A: ascii_o = 8'h76;
         8'h1D: ascii_o = 8'h77;
         8'h22: ascii_o = 8'h78;
         8'h35: ascii_o = 8'h79;
         8'h1A: ascii_o = 8'h7A; // z
         8'h45: ascii_o = 8'h30; // 0
         8'h16: ascii_o = 8'h31;
         8'h1E: ascii_o = 8'h32;
         8'h26: ascii_o = 8'h33;
         8'h25: ascii_o = 8'h34;
         8'h2E: ascii_o = 8'h35;
         8'h36: ascii_o = 8'h36;
         8'h3D: ascii_o = 8'h37;
         8'h3E: ascii_o = 8'h38;
         8'h46: ascii_o = 8'h39; // 9
         default: ascii_o = ASCII_NONE;
      endcase
   end

endmodule

// File: rtl/ps2_key_decoder.sv
// Pops scan bytes from the PS/2 receiver FIFO, decodes make/break/extended
// sequences, and tracks the newest held key, its ASCII code and a press count.
module ps2_key_decoder
   import ps2_key_decoder_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   ps2_key_decoder_if.slave kbd,
   output logic [7:0]       scan_code,
   output logic [7:0]       ascii,
   output logic             key_ext,
   output logic             key_down,
   output logic             press_pulse,
   output logic [CNT_W-1:0] key_count,
   output state_t           dbg_state
);

   state_t           state_q;
   logic             nextdata_n_q;
   logic [7:0]       scan_code_q;
   logic [7:0]       ascii_q;
   logic             key_ext_q;
   logic             key_down_q;
   logic             press_pulse_q;
   logic [CNT_W-1:0] key_count_q;
   logic             break_flag_q;
   logic             ext_flag_q;

   logic [7:0]       rom_ascii;
   logic [7:0]       ascii_d;
   logic             same_key;

   ps2_scancode_to_ascii u_rom (
      .code_i  (kbd.kbd_data),
      .ascii_o (rom_ascii)
   );

   // Extended keys share base codes with ordinary keys, so they never map to ASCII.
   assign ascii_d  = ext_flag_q ? ASCII_NONE : rom_ascii;
   assign same_key = key_down_q && (kbd.kbd_data == scan_code_q) && (ext_flag_q == key_ext_q);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= ST_WAIT;
         nextdata_n_q  <= 1'b1;
         scan_code_q   <= 8'h00;
         ascii_q       <= ASCII_NONE;
         key_ext_q     <= 1'b0;
         key_down_q    <= 1'b0;
         press_pulse_q <= 1'b0;
         key_count_q   <= '0;
         break_flag_q  <= 1'b0;
         ext_flag_q    <= 1'b0;
      end else begin
         press_pulse_q <= 1'b0;
         case (state_q)
            ST_WAIT: begin
               if (kbd.kbd_ready) begin
                  state_q      <= ST_POP;
                  nextdata_n_q <= 1'b0;
                  if (kbd.kbd_data == SC_BREAK) begin
                     break_flag_q <= 1'b1;
                  end else if (kbd.kbd_data == SC_EXT) begin
                     ext_flag_q <= 1'b1;
                  end else if (break_flag_q) begin
                     // Releases of anything but the tracked key are dropped.
                     if (same_key) key_down_q <= 1'b0;
                     break_flag_q <= 1'b0;
                     ext_flag_q   <= 1'b0;
                  end else begin
                     if (!same_key) begin
                        scan_code_q   <= kbd.kbd_data;
                        ascii_q       <= ascii_d;
                        key_ext_q     <= ext_flag_q;
                        key_down_q    <= 1'b1;
                        key_count_q   <= key_count_q + 1'b1;
                        press_pulse_q <= 1'b1;
                     end
                     ext_flag_q <= 1'b0;
                  end
               end
            end
            ST_POP: begin
               nextdata_n_q <= 1'b1;
               state_q      <= ST_GAP;
            end
            ST_GAP: begin
               state_q <= ST_WAIT;
            end
            default: begin
               nextdata_n_q <= 1'b1;
               state_q      <= ST_WAIT;
            end
         endcase
      end
   end

   assign kbd.kbd_nextdata_n = nextdata_n_q;
   assign scan_code          = scan_code_q;
   assign ascii              = ascii_q;
   assign key_ext            = key_ext_q;
   assign key_down           = key_down_q;
   assign press_pulse        = press_pulse_q;
   assign key_count          = key_count_q;
   assign dbg_state          = state_q;

endmodule
